// File: rtl/exc_pkg.sv
// Shared types and encodings for the LEGv8 exception sequencing unit.
package exc_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_ACK = 2'd1,
        HANDLER  = 2'd2,
        HALT     = 2'd3
    } exc_state_e;

    localparam logic [3:0] ES_NONE    = 4'b0000;
    localparam logic [3:0] ES_IRQ     = 4'b0001;
    localparam logic [3:0] ES_INVALID = 4'b0010;
    localparam logic [3:0] ES_ERET    = 4'b0011;
    localparam logic [3:0] ES_FATAL   = 4'b1000;

    localparam logic [10:0] OP_ERET = 11'b11010110100;

endpackage

// File: rtl/irq_sync.sv
// External interrupt synchronizer, rising-edge detector and sticky pending flag.
module irq_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic ExtIRQ,
    input  logic clr,
    output logic pend
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    // An edge coinciding with the acknowledge is kept as a fresh request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            pend   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ExtIRQ};
            prev_q <= sync_q[SYNC_STAGES-1];
            pend   <= rise | (pend & ~clr);
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception sequencer: cause prioritisation, ExcAck handshake with timeout,
// handler entry/exit tracking and interrupt masking.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] instr,
    input  logic        NotAnInstr,
    input  logic        ExtIRQ,
    input  logic        ExcAck,
    output logic        Exc,
    output logic [3:0]  EStatus,
    output logic        ERet,
    output logic        ExtIAck
);

    localparam int unsigned    CW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(ACK_TIMEOUT - 1);

    exc_state_e      state_q, state_d;
    logic [3:0]      cause_q, cause_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            irq_pend;
    logic            is_eret;
    logic [3:0]      run_cause;
    logic            exc_c, eret_c, iack_c;
    logic [3:0]      es_c;

    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
        .clk    (clk),
        .reset  (reset),
        .ExtIRQ (ExtIRQ),
        .clr    (iack_c),
        .pend   (irq_pend)
    );

    assign is_eret = (instr == OP_ERET);

    always_comb begin
        run_cause = ES_NONE;
        if (NotAnInstr)    run_cause = ES_INVALID;
        else if (is_eret)  run_cause = ES_ERET;
        else if (irq_pend) run_cause = ES_IRQ;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cause_q <= ES_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        exc_c   = 1'b0;
        es_c    = ES_NONE;
        eret_c  = 1'b0;
        iack_c  = 1'b0;
        case (state_q)
            RUN: begin
                if (run_cause != ES_NONE) begin
                    exc_c   = 1'b1;
                    es_c    = run_cause;
                    cause_d = run_cause;
                    cnt_d   = '0;
                    // Same-cycle acknowledge skips WAIT_ACK entirely.
                    if (ExcAck) begin
                        state_d = HANDLER;
                        iack_c  = (run_cause == ES_IRQ);
                    end else begin
                        state_d = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                exc_c = 1'b1;
                es_c  = cause_q;
                if (ExcAck) begin
                    state_d = HANDLER;
                    cnt_d   = '0;
                    iack_c  = (cause_q == ES_IRQ);
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HALT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HANDLER: begin
                if (NotAnInstr) begin
                    state_d = HALT;
                end else if (is_eret) begin
                    eret_c  = 1'b1;
                    state_d = RUN;
                end
            end
            HALT: begin
                exc_c = 1'b1;
                es_c  = ES_FATAL;
            end
            default: state_d = RUN;
        endcase
    end

    // Combinational outputs are forced low while reset is held.
    assign Exc     = reset & exc_c;
    assign EStatus = reset ? es_c : ES_NONE;
    assign ERet    = reset & eret_c;
    assign ExtIAck = reset & iack_c;

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception sequencing unit beside the instruction decoder in the single-cycle LEGv8 core.
- Takes the decoded opcode, the decoder's invalid-opcode flag and the external interrupt line.
- Drives Exc/EStatus into the datapath and handshakes with ExcAck from it.
- Tracks handler entry/exit, generates ERet and ExtIAck, and masks nested interrupts.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on ExtIRQ before edge detection (>=2).
- ACK_TIMEOUT, 15, max cycles in WAIT_ACK before entering HALT (>=1).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- instr  in  11  opcode field of the current instruction.
- NotAnInstr  in  1  decoder flag: opcode not implemented.
- ExtIRQ  in  1  external interrupt request, level, asynchronous to clk.
- ExcAck  in  1  datapath: ELR/ESR saved, vector fetch taken.
- Exc  out  1  exception request to datapath.
- EStatus  out  4  exception cause to datapath.
- ERet  out  1  return-from-exception select to datapath.
- ExtIAck  out  1  interrupt acknowledge to external source.

Behaviour:
- Reset:
  - While reset=0: state=RUN, counter=0, sync chain=0, irq_pend=0.
  - All outputs 0 while reset=0, including combinational ones.
- EStatus codes:
  - 0000 none.
  - 0001 external IRQ.
  - 0010 invalid opcode.
  - 0011 ERET outside handler.
  - 1000 fatal (double fault or ack timeout).
- ERET decode: instr == 11010110100.
- IRQ path:
  - ExtIRQ passes through SYNC_STAGES flops.
  - A rising edge of the synchronized signal sets irq_pend.
  - irq_pend clears only in the cycle ExtIAck=1.
  - A new edge arriving while irq_pend=1 merges into the same pending request.
- States: RUN, WAIT_ACK, HANDLER, HALT.
- RUN:
  - Cause priority: NotAnInstr (0010) > ERET (0011) > irq_pend (0001).
  - If any cause is present: Exc=1 and EStatus=cause combinationally in the same cycle. The cause is latched into cause_q and state moves to WAIT_ACK.
  - If ExcAck=1 in that same cycle, go directly to HANDLER instead (cause_q still latched).
  - If no cause is present: Exc=0, EStatus=0000, ExcAck ignored.
- WAIT_ACK:
  - Exc=1, EStatus=cause_q, counter increments each cycle.
  - On ExcAck=1: go to HANDLER and clear counter.
  - If counter reaches ACK_TIMEOUT without ExcAck: go to HALT.
- Entry to HANDLER:
  - On the transition cycle (the cycle ExcAck=1 is accepted), ExtIAck=1 for exactly that cycle, only if cause_q=0001.
  - cause_q is held through HANDLER.
- HANDLER:
  - Exc=0; irq_pend is masked but still recorded.
  - ERET decoded: ERet=1 that cycle, next state RUN. A pending IRQ is then taken on the first RUN cycle.
  - NotAnInstr=1: go to HALT.
- HALT:
  - Exc=1, EStatus=1000, ERet=0, ExtIAck=0.
  - Exit only by reset.
- Reset during any state (including mid-WAIT_ACK): immediate return to RUN. The lost request is not replayed.
- Latency:
  - Synchronous cause to Exc: 0 cycles.
  - ExtIRQ pin edge to Exc: SYNC_STAGES+1 cycles.

Decomposition:
- exc_pkg holds:
  - state enum (RUN, WAIT_ACK, HANDLER, HALT);
  - EStatus code constants;
  - ERET opcode constant.
- One sub-module, irq_sync: synchronizer chain, edge detect and irq_pend flag, with inputs clk, reset, ExtIRQ, clr and output pend.

Test Plan:
- Invalid opcode: NotAnInstr=1 in RUN with ExcAck=1 two cycles later -> Exc=1 and EStatus=0010 for 3 cycles, then HANDLER with Exc=0 and ExtIAck never 1.
- IRQ round trip: ExtIRQ 0->1 with SYNC_STAGES=2; ExcAck held 1; later ERET opcode -> Exc=1 with EStatus=0001 at cycle 3, ExtIAck=1 for one cycle, then ERet=1 for one cycle and state returns to RUN.
- Simultaneous causes: NotAnInstr=1 and irq_pend=1 in the same cycle -> EStatus=0010. After ERET, the pending IRQ gives Exc=1 with EStatus=0001 on the next cycle.
- Masking and double fault: IRQ edge while in HANDLER -> no Exc until ERET. NotAnInstr in HANDLER -> HALT with Exc=1, EStatus=1000 held for 20+ cycles.
- Stray ERET and timeout: ERET opcode in RUN -> EStatus=0011. ExcAck held 0 -> HALT with EStatus=1000 after 15 WAIT_ACK cycles.
- Reset mid-operation: reset=0 asserted mid-WAIT_ACK, asynchronously -> all outputs 0 immediately. After release: RUN, irq_pend=0.
